md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler for the E stage of the 5-stage pipeline. Owns the HI/LO registers.
- Accepts one mult/multu/div/divu/mthi/mtlo issue per start pulse and models the fixed arithmetic latency with a busy window.
- Produces the D-stage stall term that the stall unit ORs into its existing stall.
- Forwarded E-stage rs/rt values feed `a` and `b`. `hi` and `lo` feed the E-stage result mux for mfhi/mflo.

---
 rtl/md_pkg.sv | 33 +++
 rtl/md_arith.sv | 60 ++++++
 rtl/md_sched.sv | 109 ++++++++++
 tb/tb_md_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler.
// Op codes arrive with start; 7 is reserved and decodes as no operation.
package md_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic op_is_mul(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_long(input logic [2:0] o);
    return op_is_mul(o) || op_is_div(o);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product and quotient/remainder for the md scheduler.
// Signed division works on magnitudes, so MIN / -1 wraps to MIN with zero remainder.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   mag_a;
  logic        [WIDTH-1:0]   mag_b;
  logic        [WIDTH-1:0]   mag_q;
  logic        [WIDTH-1:0]   mag_r;
  logic        [WIDTH-1:0]   quo;
  logic        [WIDTH-1:0]   rem;
  logic                      is_sdiv;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign is_sdiv     = (op == OP_DIV);
  assign div_by_zero = (b == '0);

  assign mag_a = neg_if(is_sdiv && a[WIDTH-1], a);
  assign mag_b = neg_if(is_sdiv && b[WIDTH-1], b);

  // Guarded so a zero divisor never reaches the divider; the result is discarded anyway.
  assign mag_q = div_by_zero ? '0 : (mag_a / mag_b);
  assign mag_r = div_by_zero ? '0 : (mag_a % mag_b);

  assign quo = neg_if(is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]), mag_q);
  assign rem = neg_if(is_sdiv && a[WIDTH-1], mag_r);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        res_hi = rem;
        res_lo = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, models fixed latency with a busy window
// and raises the D-stage stall while an md-class instruction would collide.
module md_sched
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_is_md,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             no_write;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_by_zero;
  logic             issue_long;

  md_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .op         (op),
    .a          (a),
    .b          (b),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_by_zero(div_by_zero)
  );

  assign issue_long = (state == IDLE) && start && op_is_long(op);

  assign md_stall = d_is_md & (busy | (start & op_is_long(op)));

  // Operands are captured only at issue; later changes on a/b are irrelevant.
  always_ff @(posedge clk) begin
    if (issue_long) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      no_write <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                cnt      <= CNT_W'(MULT_CYCLES);
                no_write <= 1'b0;
                busy     <= 1'b1;
                state    <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                cnt      <= CNT_W'(DIV_CYCLES);
                no_write <= div_by_zero;
                busy     <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here; the stall keeps the pipeline from issuing.
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
            if (!no_write) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: a plain-arithmetic HI/LO model predicts each
// long op's result and latency; a negedge monitor pops when busy falls.
module tb_md_sched;
  import md_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         d_is_md;
  logic         busy;
  logic         md_stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  bit          mon_en = 0;
  bit          prev_busy = 0;
  int          run_len = 0;

  md_sched #(
    .WIDTH(W),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the arithmetic definitions, on 64-bit integers.
  function automatic exp_t model_long(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t e;
    longint sx, sy, p, q, r;
    longint unsigned ux, uy, up, uq, ur;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    e.hi  = cur_hi;
    e.lo  = cur_lo;
    e.lat = (o == OP_MULT || o == OP_MULTU) ? 5 : 10;
    case (o)
      OP_MULT: begin
        p = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OP_MULTU: begin
        up = ux * uy;
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      OP_DIV: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end
      OP_DIVU: if (y != 0) begin
        uq = ux / uy;
        ur = ux % uy;
        e.lo = uq[31:0];
        e.hi = ur[31:0];
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic monitor();
    logic exp_stall;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_stall = d_is_md & (busy | (start & (op >= 3'd1) & (op <= 3'd4)));
        check("md_stall", {63'd0, md_stall}, {63'd0, exp_stall});
        if (busy) begin
          run_len++;
        end else if (prev_busy) begin
          check("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("busy_len", 64'(run_len), 64'(e.lat));
            check("hi_result", {32'd0, hi}, {32'd0, e.hi});
            check("lo_result", {32'd0, lo}, {32'd0, e.lo});
          end
          run_len = 0;
        end
        prev_busy = busy;
      end
    end
  endtask

  task automatic randomize_idle_inputs();
    op      = 3'($urandom_range(0, 7));
    a       = $urandom;
    b       = $urandom;
    d_is_md = 1'($urandom_range(0, 1));
  endtask

  // Drive one issue in the current cycle and run it to completion.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bit   lng;
    int   n;
    lng     = (o >= OP_MULT) && (o <= OP_DIVU);
    start   = 1'b1;
    op      = o;
    a       = x;
    b       = y;
    d_is_md = 1'($urandom_range(0, 1));
    if (lng) begin
      e = model_long(o, x, y, m_hi, m_lo);
      sb.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end else if (o == OP_MTHI) begin
      m_hi = x;
    end else if (o == OP_MTLO) begin
      m_lo = x;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    randomize_idle_inputs();
    if (!lng) begin
      check("short_busy", {63'd0, busy}, 64'd0);
      check("short_hi", {32'd0, hi}, {32'd0, m_hi});
      check("short_lo", {32'd0, lo}, {32'd0, m_lo});
    end else begin
      n = 0;
      while (busy && n < 40) begin
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          op    = 3'($urandom_range(1, 6));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        randomize_idle_inputs();
        n++;
      end
      check("busy_done", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rb;
    reset   = 1'b0;
    start   = 1'b0;
    op      = OP_NONE;
    a       = '0;
    b       = '0;
    d_is_md = 1'b1;
    m_hi    = '0;
    m_lo    = '0;
    fork
      monitor();
    join_none

    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, md_stall}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    #11 reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    issue(OP_DIVU, 32'd17, 32'd5);
    issue(OP_DIV, 32'hFFFF_FFEF, 32'd5);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_MTHI, 32'h11, 32'd0);
    issue(OP_MTLO, 32'h22, 32'd0);
    issue(OP_DIV, 32'd1234, 32'd0);
    check("div0_hi_kept", {32'd0, hi}, 64'h11);
    check("div0_lo_kept", {32'd0, lo}, 64'h22);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    issue(OP_MTLO, 32'h1234_5678, 32'd0);
    check("mt_hi", {32'd0, hi}, 64'hDEAD_BEEF);

    // Asynchronous reset in the third busy cycle of a MULT.
    mon_en  = 0;
    start   = 1'b1;
    op      = OP_MULT;
    a       = 32'd7;
    b       = 32'd9;
    d_is_md = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_stall_idle", {63'd0, md_stall}, 64'd0);
    start = 1'b1;
    op    = OP_MULT;
    #1;
    check("arst_stall_start", {63'd0, md_stall}, 64'd1);
    op = OP_MTHI;
    #1;
    check("arst_stall_mthi", {63'd0, md_stall}, 64'd0);
    start = 1'b0;
    @(posedge clk);
    #3;
    check("arst_hold_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;
    m_hi  = '0;
    m_lo  = '0;
    @(posedge clk);
    #1;
    prev_busy = 0;
    run_len   = 0;
    mon_en    = 1;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi", {32'd0, hi}, 64'h1);
    check("multu_lo", {32'd0, lo}, 64'hFFFF_FFFE);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      issue(ro, $urandom, rb);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
